// File: rtl/neander_pkg.sv
// Shared definitions for the Neander accumulator core: opcodes, controller
// states, ALU operation codes and small opcode classification helpers.
package neander_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JN  = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_DECODE,
    ST_ADDR,
    ST_READ,
    ST_WRITE,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_PASS,
    ALU_ADD,
    ALU_OR,
    ALU_AND,
    ALU_NOT
  } alu_op_t;

  // Instructions that fetch an operand address and then touch data memory.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_STA) || (op == OP_LDA) || (op == OP_ADD) ||
           (op == OP_OR)  || (op == OP_AND);
  endfunction

  // Instructions whose operand word is a new PC value.
  function automatic logic is_jump(input logic [3:0] op);
    return (op == OP_JMP) || (op == OP_JN) || (op == OP_JZ);
  endfunction

  // ALU operation used when an instruction writes the accumulator.
  function automatic alu_op_t alu_op_for(input logic [3:0] op);
    alu_op_t r;
    case (op)
      OP_ADD:  r = ALU_ADD;
      OP_OR:   r = ALU_OR;
      OP_AND:  r = ALU_AND;
      OP_NOT:  r = ALU_NOT;
      default: r = ALU_PASS;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/neander_alu.sv
// Combinational Neander ALU. Operand a is the accumulator, b the memory word.
// Addition wraps with no carry out; flags are derived from the result.
module neander_alu
  import neander_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  alu_op_t               op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic [1:0]            nz
);

  // Select the result for the requested operation.
  always_comb begin
    result = b;
    case (op)
      ALU_PASS: result = b;
      ALU_ADD:  result = a + b;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      ALU_NOT:  result = ~a;
      default:  result = b;
    endcase
  end

  assign nz = {result[DATA_WIDTH-1], (result == '0)};

endmodule

// File: rtl/neander_core.sv
// Neander accumulator processor core with an external single-port memory
// bus. Every memory access completes on an edge where mem_req & mem_ready;
// while mem_ready is low all state and bus outputs hold.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// BOOT     | one idle cycle after reset, no bus request
// FETCH    | read opcode word at PC, PC advances
// DECODE   | execute single-word ops, resolve branch condition
// ADDR     | read operand word at PC; jumps load PC from it
// READ     | read data at operand, AC <= ALU(AC, data)
// WRITE    | write AC at operand
// HALT     | stopped by HLT until reset
module neander_core
  import neander_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk_geral,
  input  logic                  reset_geral,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0] ac_out,
  output logic [1:0]            nz_out,
  output logic                  halted,
  output logic                  retire
);

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   pc;
  logic [ADDR_WIDTH-1:0]   operand;
  logic [DATA_WIDTH-1:0]   ac;
  logic [3:0]              ir_op;
  logic                    flag_n;
  logic                    flag_z;

  alu_op_t                 alu_op;
  logic [DATA_WIDTH-1:0]   alu_result;
  logic [1:0]              alu_nz;

  logic                    branch_taken;
  logic                    decode_to_addr;

  // Only the opcode nibble of IR is ever consulted, so only it is kept.
  assign alu_op         = alu_op_for(ir_op);
  assign branch_taken   = ((ir_op == OP_JN) && flag_n) || ((ir_op == OP_JZ) && flag_z);
  assign decode_to_addr = is_mem_op(ir_op) || (ir_op == OP_JMP) || branch_taken;

  neander_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .op    (alu_op),
    .a     (ac),
    .b     (mem_rdata),
    .result(alu_result),
    .nz    (alu_nz)
  );

  // Controller and architectural registers; every transition out of a bus
  // state is gated by mem_ready so wait states freeze the whole core.
  always_ff @(posedge clk_geral) begin
    if (reset_geral) begin
      state   <= ST_BOOT;
      pc      <= RESET_PC;
      operand <= '0;
      ac      <= '0;
      ir_op   <= OP_NOP;
      flag_n  <= 1'b0;
      flag_z  <= 1'b1;
    end else begin
      case (state)
        ST_BOOT: state <= ST_FETCH;

        ST_FETCH: begin
          if (mem_ready) begin
            ir_op <= mem_rdata[DATA_WIDTH-1 -: 4];
            pc    <= pc + PC_ONE;
            state <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          if (ir_op == OP_HLT) begin
            state <= ST_HALT;
          end else if (decode_to_addr) begin
            state <= ST_ADDR;
          end else begin
            state <= ST_FETCH;
            if (ir_op == OP_NOT) begin
              ac     <= alu_result;
              flag_n <= alu_nz[1];
              flag_z <= alu_nz[0];
            end
            // An untaken branch still has to step over its operand word.
            if ((ir_op == OP_JN) || (ir_op == OP_JZ)) begin
              pc <= pc + PC_ONE;
            end
          end
        end

        ST_ADDR: begin
          if (mem_ready) begin
            operand <= mem_rdata[ADDR_WIDTH-1:0];
            if (is_jump(ir_op)) begin
              pc    <= mem_rdata[ADDR_WIDTH-1:0];
              state <= ST_FETCH;
            end else begin
              pc    <= pc + PC_ONE;
              state <= (ir_op == OP_STA) ? ST_WRITE : ST_READ;
            end
          end
        end

        ST_READ: begin
          if (mem_ready) begin
            ac     <= alu_result;
            flag_n <= alu_nz[1];
            flag_z <= alu_nz[0];
            state  <= ST_FETCH;
          end
        end

        ST_WRITE: begin
          if (mem_ready) begin
            state <= ST_FETCH;
          end
        end

        ST_HALT: state <= ST_HALT;

        default: state <= ST_BOOT;
      endcase
    end
  end

  // Bus outputs decode the registered state only, so they cannot move
  // during a wait.
  assign mem_req   = (state == ST_FETCH) || (state == ST_ADDR) ||
                     (state == ST_READ)  || (state == ST_WRITE);
  assign mem_we    = (state == ST_WRITE);
  assign mem_addr  = ((state == ST_READ) || (state == ST_WRITE)) ? operand : pc;
  assign mem_wdata = ac;

  // Retire flags the cycle whose closing edge finishes an instruction.
  always_comb begin
    retire = 1'b0;
    case (state)
      ST_DECODE: retire = !decode_to_addr;
      ST_ADDR:   retire = mem_ready && is_jump(ir_op);
      ST_READ:   retire = mem_ready;
      ST_WRITE:  retire = mem_ready;
      default:   retire = 1'b0;
    endcase
  end

  assign pc_out = pc;
  assign ac_out = ac;
  assign nz_out = {flag_n, flag_z};
  assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_neander_core.sv
// Directed bench for neander_core (8/8, RESET_PC=0) with a behavioural
// memory that can insert wait states or stall writes.
module tb_neander_core;

  logic       clk_geral = 1'b0;
  logic       reset_geral;
  logic       mem_req, mem_we, mem_ready;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0] pc_out, ac_out;
  logic [1:0] nz_out;
  logic       halted, retire;

  int n_cmp = 0;
  int n_err = 0;

  // memory model: 0 = always ready, 1 = two wait cycles per access, 2 = writes stall
  logic [7:0] mem [256];
  logic [1:0] rdy_mode;
  logic [1:0] wait_cnt;
  logic       clr_en, load_en;
  logic [7:0] load_addr, load_data;
  int         wr_count;

  always #5 clk_geral = ~clk_geral;

  neander_core #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(8),
    .RESET_PC  (8'h00)
  ) dut (
    .clk_geral  (clk_geral),
    .reset_geral(reset_geral),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .pc_out     (pc_out),
    .ac_out     (ac_out),
    .nz_out     (nz_out),
    .halted     (halted),
    .retire     (retire)
  );

  assign mem_rdata = mem[mem_addr];

  always_comb begin
    case (rdy_mode)
      2'd0:    mem_ready = 1'b1;
      2'd1:    mem_ready = mem_req && (wait_cnt == 2'd2);
      default: mem_ready = !mem_we;
    endcase
  end

  always @(posedge clk_geral) begin
    if (!mem_req || mem_ready) wait_cnt <= 2'd0;
    else                       wait_cnt <= wait_cnt + 2'd1;
  end

  always @(posedge clk_geral) begin
    if (clr_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      wr_count <= 0;
    end else if (load_en) begin
      mem[load_addr] <= load_data;
    end else if (mem_req && mem_ready && mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_count      <= wr_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Put the core in reset and wipe memory.
  task automatic prep();
    reset_geral = 1'b1;
    clr_en = 1'b1;
    @(posedge clk_geral); #1;
    clr_en = 1'b0;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk_geral); #1;
    load_en = 1'b0;
  endtask

  task automatic load_straight();
    poke(8'h00, 8'h20); poke(8'h01, 8'h80);
    poke(8'h02, 8'h30); poke(8'h03, 8'h81);
    poke(8'h04, 8'h10); poke(8'h05, 8'h82);
    poke(8'h06, 8'hF0);
    poke(8'h80, 8'h05); poke(8'h81, 8'h07);
  endtask

  // Release reset and run until halted; edges are numbered from release.
  task automatic run_prog(input int max_edges, output int halt_edge,
                          output int n_ret, output int n_unstable);
    logic        seen_wait;
    logic [17:0] snap;
    halt_edge = -1; n_ret = 0; n_unstable = 0; seen_wait = 1'b0; snap = '0;
    @(negedge clk_geral);
    reset_geral = 1'b0;
    for (int k = 1; k <= max_edges && halt_edge < 0; k++) begin
      if (seen_wait && ({mem_req, mem_we, mem_addr, mem_wdata} !== snap)) n_unstable++;
      seen_wait = mem_req && !mem_ready;
      snap = {mem_req, mem_we, mem_addr, mem_wdata};
      if (retire) n_ret++;
      @(posedge clk_geral); #1;
      if (halted) halt_edge = k;
      @(negedge clk_geral);
    end
  endtask

  int he, nr, nu;

  initial begin
    reset_geral = 1'b1; rdy_mode = 2'd0;
    clr_en = 1'b0; load_en = 1'b0; load_addr = 8'h00; load_data = 8'h00;
    prep();
    @(posedge clk_geral); #1;
    chk("rst_req",    32'(mem_req),   32'h0);
    chk("rst_we",     32'(mem_we),    32'h0);
    chk("rst_addr",   32'(mem_addr),  32'h00);
    chk("rst_wdata",  32'(mem_wdata), 32'h00);
    chk("rst_pc",     32'(pc_out),    32'h00);
    chk("rst_ac",     32'(ac_out),    32'h00);
    chk("rst_nz",     32'(nz_out),    32'h1);
    chk("rst_halted", 32'(halted),    32'h0);
    chk("rst_retire", 32'(retire),    32'h0);
    @(negedge clk_geral);
    reset_geral = 1'b0;
    @(posedge clk_geral); #1;
    chk("first_req",  32'(mem_req),  32'h1);
    chk("first_addr", 32'(mem_addr), 32'h00);

    // straight-line program, zero wait
    prep(); load_straight();
    run_prog(60, he, nr, nu);
    chk("sl_halt_edge", 32'(he),        32'd15);
    chk("sl_retires",   32'(nr),        32'd4);
    chk("sl_mem82",     32'(mem[8'h82]), 32'h0C);
    chk("sl_ac",        32'(ac_out),    32'h0C);
    chk("sl_nz",        32'(nz_out),    32'h0);
    chk("sl_pc",        32'(pc_out),    32'h07);
    chk("sl_writes",    32'(wr_count),  32'd1);

    // same program, two wait cycles before every access
    rdy_mode = 2'd1;
    prep(); load_straight();
    run_prog(80, he, nr, nu);
    chk("ws_halt_edge", 32'(he),        32'd35);
    chk("ws_retires",   32'(nr),        32'd4);
    chk("ws_unstable",  32'(nu),        32'd0);
    chk("ws_mem82",     32'(mem[8'h82]), 32'h0C);
    chk("ws_ac",        32'(ac_out),    32'h0C);
    chk("ws_nz",        32'(nz_out),    32'h0);
    rdy_mode = 2'd0;

    // JZ taken after loading zero
    prep();
    poke(8'h00, 8'h20); poke(8'h01, 8'h80);
    poke(8'h02, 8'hA0); poke(8'h03, 8'h10);
    poke(8'h04, 8'hF0); poke(8'h10, 8'hF0);
    run_prog(40, he, nr, nu);
    chk("jz_halt_edge", 32'(he),     32'd10);
    chk("jz_pc",        32'(pc_out), 32'h11);
    chk("jz_nz",        32'(nz_out), 32'h1);
    chk("jz_retires",   32'(nr),     32'd3);

    // JN not taken with N=0
    prep();
    poke(8'h00, 8'h20); poke(8'h01, 8'h80);
    poke(8'h02, 8'h90); poke(8'h03, 8'h20);
    poke(8'h04, 8'hF0); poke(8'h20, 8'hF0);
    poke(8'h80, 8'h05);
    run_prog(40, he, nr, nu);
    chk("jnn_halt_edge", 32'(he),     32'd9);
    chk("jnn_pc",        32'(pc_out), 32'h05);
    chk("jnn_ac",        32'(ac_out), 32'h05);

    // JN taken with N=1
    prep();
    poke(8'h00, 8'h20); poke(8'h01, 8'h80);
    poke(8'h02, 8'h90); poke(8'h03, 8'h20);
    poke(8'h04, 8'hF0); poke(8'h20, 8'hF0);
    poke(8'h80, 8'h85);
    run_prog(40, he, nr, nu);
    chk("jnt_halt_edge", 32'(he),     32'd10);
    chk("jnt_pc",        32'(pc_out), 32'h21);
    chk("jnt_nz",        32'(nz_out), 32'h2);

    // LDA 7F, NOT
    prep();
    poke(8'h00, 8'h20); poke(8'h01, 8'h80);
    poke(8'h02, 8'h60); poke(8'h03, 8'hF0);
    poke(8'h80, 8'h7F);
    run_prog(40, he, nr, nu);
    chk("not_halt_edge", 32'(he),     32'd9);
    chk("not_ac",        32'(ac_out), 32'h80);
    chk("not_nz",        32'(nz_out), 32'h2);

    // LDA 7F, NOT, AND 00
    prep();
    poke(8'h00, 8'h20); poke(8'h01, 8'h80);
    poke(8'h02, 8'h60); poke(8'h03, 8'h50);
    poke(8'h04, 8'h81); poke(8'h05, 8'hF0);
    poke(8'h80, 8'h7F);
    run_prog(40, he, nr, nu);
    chk("and_halt_edge", 32'(he),     32'd13);
    chk("and_ac",        32'(ac_out), 32'h00);
    chk("and_nz",        32'(nz_out), 32'h1);
    chk("and_pc",        32'(pc_out), 32'h06);

    // reset while a write is stalled
    rdy_mode = 2'd2;
    prep();
    poke(8'h00, 8'h20); poke(8'h01, 8'h80);
    poke(8'h02, 8'h10); poke(8'h03, 8'h90);
    poke(8'h04, 8'hF0); poke(8'h80, 8'h33);
    @(negedge clk_geral);
    reset_geral = 1'b0;
    for (int k = 0; k < 40 && !mem_we; k++) @(negedge clk_geral);
    chk("wr_stall_we",    32'(mem_we),    32'h1);
    chk("wr_stall_addr",  32'(mem_addr),  32'h90);
    chk("wr_stall_wdata", 32'(mem_wdata), 32'h33);
    repeat (2) @(negedge clk_geral);
    chk("wr_stall_hold",  32'(mem_addr),  32'h90);
    reset_geral = 1'b1;
    @(posedge clk_geral); #1;
    chk("wr_rst_req",    32'(mem_req),    32'h0);
    chk("wr_rst_pc",     32'(pc_out),     32'h00);
    chk("wr_rst_ac",     32'(ac_out),     32'h00);
    chk("wr_rst_mem90",  32'(mem[8'h90]), 32'h00);
    chk("wr_rst_writes", 32'(wr_count),   32'd0);
    rdy_mode = 2'd0;

    // PC wrap: JMP FE, NOP at FE and FF
    prep();
    poke(8'h00, 8'h80); poke(8'h01, 8'hFE);
    @(negedge clk_geral);
    reset_geral = 1'b0;
    repeat (4) @(posedge clk_geral); #1;
    chk("wrap_jmp_pc",   32'(pc_out),   32'hFE);
    chk("wrap_jmp_addr", 32'(mem_addr), 32'hFE);
    repeat (4) @(posedge clk_geral); #1;
    chk("wrap_req",  32'(mem_req),  32'h1);
    chk("wrap_addr", 32'(mem_addr), 32'h00);
    chk("wrap_pc",   32'(pc_out),   32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
